ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the EX stage of the MIPS32 pipeline. Owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Multiply uses a registered partial-product pipeline; divide uses an iterative restoring divider. A start/busy/done handshake lets the hazard unit stall IF/ID while the unit is occupied.

---
 rtl/ex_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- EX-stage multiply/divide unit that owns the HI/LO registers.
// Multiply: operand magnitudes are split into four half-width partial products
// that are registered at issue, then summed and sign-corrected on the last MUL
// cycle. Divide: restoring divider producing one quotient bit per cycle (the
// first bit is produced at issue), followed by a FIX cycle that applies signs.
// busy stays high through the done cycle; a start in the done cycle is accepted.
// Optional feature macro: MULDIV_MADD_EN (enables MADD/MADDU/MSUB/MSUBU, ops 7-10).
module ex_muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 2);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 2);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} stateT;

  // Two's-complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
    negW = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Full-width product of two half-width values.
  function automatic logic [WIDTH-1:0] mulHalf(input logic [HALF-1:0] a, input logic [HALF-1:0] b);
    mulHalf = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
  endfunction

  // One restoring-division step; returns {newRemainder, newDividendQuotient}.
  function automatic logic [2*WIDTH-1:0] divStep(input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] dvd,
                                                 input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    shifted = {rem, dvd[WIDTH-1]};
    if (shifted >= {1'b0, dvs}) begin
      divStep = {shifted[WIDTH-1:0] - dvs, dvd[WIDTH-2:0], 1'b1};
    end else begin
      divStep = {shifted[WIDTH-1:0], dvd[WIDTH-2:0], 1'b0};
    end
  endfunction

  stateT state, nextState;
  logic isMul, isDiv, isSigned, issueOk;
  logic [WIDTH-1:0] magA, magB;
  logic [WIDTH-1:0] ppLL, ppLH, ppHL, ppHH;
  logic mulNeg, quotNeg, remNeg, divZero;
  logic [WIDTH-1:0] divRem, divQuo, divDvs, dividendRaw;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] entryStep, iterStep, prodMag, product, mulResult;
  logic [WIDTH-1:0] divHi, divLo;
  logic busyNext, doneNext;
  logic [WIDTH-1:0] hiNext, loNext;
`ifdef MULDIV_MADD_EN
  logic [1:0] accSel, accMode;
`endif

  // Classify the requested op; unknown or disabled codes fall through as no-ops.
  always_comb begin
    isMul    = 1'b0;
    isDiv    = 1'b0;
    isSigned = 1'b0;
`ifdef MULDIV_MADD_EN
    accSel   = ACC_NONE;
`endif
    case (op)
      OP_MULT:  begin isMul = 1'b1; isSigned = 1'b1; end
      OP_MULTU: begin isMul = 1'b1; end
      OP_DIV:   begin isDiv = 1'b1; isSigned = 1'b1; end
      OP_DIVU:  begin isDiv = 1'b1; end
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin isMul = 1'b1; isSigned = 1'b1; accSel = ACC_ADD; end
      OP_MADDU: begin isMul = 1'b1; accSel = ACC_ADD; end
      OP_MSUB:  begin isMul = 1'b1; isSigned = 1'b1; accSel = ACC_SUB; end
      OP_MSUBU: begin isMul = 1'b1; accSel = ACC_SUB; end
`endif
      default:  begin isMul = 1'b0; isDiv = 1'b0; isSigned = 1'b0; end
    endcase
  end

  assign issueOk   = start && !flush && (state == IDLE);
  assign magA      = (isSigned && busA[WIDTH-1]) ? negW(busA) : busA;
  assign magB      = (isSigned && busB[WIDTH-1]) ? negW(busB) : busB;
  assign entryStep = divStep({WIDTH{1'b0}}, magA, magB);
  assign iterStep  = divStep(divRem, divQuo, divDvs);

  assign prodMag = {ppHH, ppLL}
                 + {{HALF{1'b0}}, ppLH, {HALF{1'b0}}}
                 + {{HALF{1'b0}}, ppHL, {HALF{1'b0}}};
  assign product = mulNeg ? (~prodMag + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prodMag;

  // Final multiply value, optionally accumulated onto the current HI/LO.
  always_comb begin
`ifdef MULDIV_MADD_EN
    case (accMode)
      ACC_ADD: mulResult = {hi, lo} + product;
      ACC_SUB: mulResult = {hi, lo} - product;
      default: mulResult = product;
    endcase
`else
    mulResult = product;
`endif
  end

  // Signed fix-up of the divider result, with divide-by-zero override.
  always_comb begin
    if (divZero) begin
      divLo = {WIDTH{1'b1}};
      divHi = dividendRaw;
    end else begin
      divLo = quotNeg ? negW(divQuo) : divQuo;
      divHi = remNeg ? negW(divRem) : divRem;
    end
  end

  // Operand capture, partial products and divider iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppLL <= {WIDTH{1'b0}}; ppLH <= {WIDTH{1'b0}};
      ppHL <= {WIDTH{1'b0}}; ppHH <= {WIDTH{1'b0}};
      mulNeg <= 1'b0; quotNeg <= 1'b0; remNeg <= 1'b0; divZero <= 1'b0;
      divRem <= {WIDTH{1'b0}}; divQuo <= {WIDTH{1'b0}};
      divDvs <= {WIDTH{1'b0}}; dividendRaw <= {WIDTH{1'b0}};
      cnt <= {CW{1'b0}};
`ifdef MULDIV_MADD_EN
      accMode <= 2'd0;
`endif
    end else if (issueOk && isMul) begin
      ppLL   <= mulHalf(magA[HALF-1:0],     magB[HALF-1:0]);
      ppLH   <= mulHalf(magA[HALF-1:0],     magB[WIDTH-1:HALF]);
      ppHL   <= mulHalf(magA[WIDTH-1:HALF], magB[HALF-1:0]);
      ppHH   <= mulHalf(magA[WIDTH-1:HALF], magB[WIDTH-1:HALF]);
      mulNeg <= isSigned & (busA[WIDTH-1] ^ busB[WIDTH-1]);
      cnt    <= {CW{1'b0}};
`ifdef MULDIV_MADD_EN
      accMode <= accSel;
`endif
    end else if (issueOk && isDiv) begin
      divRem      <= entryStep[2*WIDTH-1:WIDTH];
      divQuo      <= entryStep[WIDTH-1:0];
      divDvs      <= magB;
      quotNeg     <= isSigned & (busA[WIDTH-1] ^ busB[WIDTH-1]);
      remNeg      <= isSigned & busA[WIDTH-1];
      divZero     <= (busB == {WIDTH{1'b0}});
      dividendRaw <= busA;
      cnt         <= {CW{1'b0}};
    end else if (state == DIV) begin
      divRem <= iterStep[2*WIDTH-1:WIDTH];
      divQuo <= iterStep[WIDTH-1:0];
      cnt    <= cnt + CW'(1);
    end else if (state == MUL) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next-state logic; flush returns any busy state to IDLE.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (issueOk && isMul) nextState = MUL;
        else if (issueOk && isDiv) nextState = DIV;
        else nextState = IDLE;
      end
      MUL: begin
        if (flush || (cnt == MUL_LAST)) nextState = IDLE;
        else nextState = MUL;
      end
      DIV: begin
        if (flush) nextState = IDLE;
        else if (cnt == DIV_LAST) nextState = FIX;
        else nextState = DIV;
      end
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Next values of the registered outputs: write-back, MTHI/MTLO, busy/done.
  always_comb begin
    busyNext = 1'b0;
    doneNext = 1'b0;
    hiNext   = hi;
    loNext   = lo;
    case (state)
      IDLE: begin
        if (issueOk && (isMul || isDiv)) busyNext = 1'b1;
        else if (issueOk && (op == OP_MTHI)) hiNext = busA;
        else if (issueOk && (op == OP_MTLO)) loNext = busA;
        else busyNext = 1'b0;
      end
      MUL: begin
        if (flush) begin
          busyNext = 1'b0;
        end else if (cnt == MUL_LAST) begin
          busyNext = 1'b1;
          doneNext = 1'b1;
          {hiNext, loNext} = mulResult;
        end else begin
          busyNext = 1'b1;
        end
      end
      DIV: begin
        if (flush) busyNext = 1'b0;
        else busyNext = 1'b1;
      end
      FIX: begin
        if (flush) begin
          busyNext = 1'b0;
        end else begin
          busyNext = 1'b1;
          doneNext = 1'b1;
          hiNext   = divHi;
          loNext   = divLo;
        end
      end
      default: busyNext = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= {WIDTH{1'b0}};
      lo   <= {WIDTH{1'b0}};
    end else begin
      busy <= busyNext;
      done <= doneNext;
      hi   <= hiNext;
      lo   <= loNext;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit -- directed and randomized bench for ex_muldiv_unit with an
// arithmetic reference model (pending-operation countdown plus plain * / %).
// Honours MULDIV_MADD_EN the same way as the design.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
  localparam int MS = 2;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [3:0] op = 4'd0;
  logic [31:0] busA = 32'd0, busB = 32'd0;
  logic busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  ex_muldiv_unit #(.WIDTH(32), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busA(busA), .busB(busB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic.
  function automatic logic [63:0] mulRef(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x;
    if (sgn) begin
      x = longint'($signed(a)) * longint'($signed(b));
      return 64'(x);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] divRef(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Reference model: one pending operation counting down to its write-back.
  logic [31:0] mHi = 32'd0, mLo = 32'd0;
  logic mBusy = 1'b0, mDone = 1'b0;
  bit pend = 1'b0;
  bit pMul = 1'b0;
  int remCyc = 0;
  int pAcc = 0;
  logic [63:0] pRes = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHi = 32'd0; mLo = 32'd0; mBusy = 1'b0; mDone = 1'b0; pend = 1'b0; remCyc = 0;
    end else begin
      mDone = 1'b0;
      if (pend) begin
        if (flush) begin
          pend = 1'b0;
        end else begin
          remCyc--;
          if (remCyc == 0) begin
            pend = 1'b0;
            mDone = 1'b1;
            if (pMul && pAcc == 1) {mHi, mLo} = {mHi, mLo} + pRes;
            else if (pMul && pAcc == 2) {mHi, mLo} = {mHi, mLo} - pRes;
            else {mHi, mLo} = pRes;
          end
        end
      end else if (start && !flush) begin
        case (op)
          4'd1, 4'd2: begin pend = 1'b1; pMul = 1'b1; pAcc = 0; remCyc = MS - 1; pRes = mulRef(op == 4'd1, busA, busB); end
          4'd3, 4'd4: begin pend = 1'b1; pMul = 1'b0; pAcc = 0; remCyc = 32; pRes = divRef(op == 4'd3, busA, busB); end
          4'd5: mHi = busA;
          4'd6: mLo = busA;
`ifdef MULDIV_MADD_EN
          4'd7, 4'd8, 4'd9, 4'd10: begin
            pend = 1'b1; pMul = 1'b1; remCyc = MS - 1;
            pAcc = (op <= 4'd8) ? 1 : 2;
            pRes = mulRef(op == 4'd7 || op == 4'd9, busA, busB);
          end
`endif
          default: ;
        endcase
      end
      mBusy = pend || mDone;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("cyc busy", busy, mBusy);
      check("cyc done", done, mDone);
      check("cyc hi", hi, mHi);
      check("cyc lo", lo, mLo);
    end
  end

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait (bounded) for done; optionally poke start while busy.
  task automatic runOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output int lat, output int busyCyc);
    logic [31:0] h0, l0;
    lat = -1;
    busyCyc = 0;
    start = 1'b1; op = o; busA = a; busB = b;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    h0 = hi; l0 = lo;
    for (int k = 1; k <= 60; k++) begin
      start = 1'b0;
      if (busy) busyCyc++;
      if (done) begin
        lat = k;
        break;
      end
      if (poke) begin
        check("held hi", hi, h0);
        check("held lo", lo, l0);
        if (k % 3 == 1) begin start = 1'b1; op = 4'd1; busA = $urandom; busB = $urandom; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; op = 4'd0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, nd;
    #2 rst_n = 1'b0;
    #1 checkEn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOp(4'd1, 32'hFFFFFFFF, 32'h2, 1'b0, lat, bc);
    check("MULT latency", lat, 2);
    check("MULT hi", hi, 32'hFFFFFFFF);
    check("MULT lo", lo, 32'hFFFFFFFE);
    check("model MULT hi", mHi, 32'hFFFFFFFF);

    runOp(4'd2, 32'hFFFFFFFF, 32'h2, 1'b0, lat, bc);
    check("MULTU latency", lat, 2);
    check("MULTU busy cycles", bc, 2);
    check("MULTU hi", hi, 32'h1);
    check("MULTU lo", lo, 32'hFFFFFFFE);
    @(posedge clk); #1;
    check("MULTU busy after", busy, 1'b0);

    runOp(4'd3, 32'hFFFFFFF9, 32'h2, 1'b0, lat, bc);
    check("DIV latency", lat, 33);
    check("DIV lo", lo, 32'hFFFFFFFD);
    check("DIV hi", hi, 32'hFFFFFFFF);
    check("model DIV lo", mLo, 32'hFFFFFFFD);

    runOp(4'd4, 32'd100, 32'd0, 1'b0, lat, bc);
    check("DIVU0 hi", hi, 32'h64);
    check("DIVU0 lo", lo, 32'hFFFFFFFF);

    runOp(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bc);
    check("DIVOVF latency", lat, 33);
    check("DIVOVF lo", lo, 32'h80000000);
    check("DIVOVF hi", hi, 32'h0);

    // MTHI, then a DIVU flushed in its fifth cycle
    start = 1'b1; op = 4'd5; busA = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    check("MTHI busy", busy, 1'b0);
    check("MTHI done", done, 1'b0);
    check("MTHI hi", hi, 32'h12345678);
    start = 1'b1; op = 4'd4; busA = 32'd10; busB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", busy, 1'b0);
    check("flush done", done, 1'b0);
    check("flush hi", hi, 32'h12345678);
    check("flush lo", lo, 32'h80000000);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    check("flush no done", nd, 0);

    // Reset in the middle of a MULT
    start = 1'b1; op = 4'd1; busA = 32'd3; busB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    check("pre-reset busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Accumulating multiply (op 8, MADDU) onto hi=0, lo=all ones
    start = 1'b1; op = 4'd6; busA = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b1; op = 4'd8; busA = 32'd1; busB = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
`ifdef MULDIV_MADD_EN
    check("MADDU busy", busy, 1'b1);
    @(posedge clk); #1;
    check("MADDU done", done, 1'b1);
    check("MADDU hi", hi, 32'h1);
    check("MADDU lo", lo, 32'h0);
`else
    check("op8 busy", busy, 1'b0);
    @(posedge clk); #1;
    check("op8 done", done, 1'b0);
    check("op8 hi", hi, 32'h0);
    check("op8 lo", lo, 32'hFFFFFFFF);
`endif

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 99) < 35);
      op = 4'($urandom_range(0, 12));
      busA = pickVal();
      busB = pickVal();
      flush = ($urandom_range(0, 99) < 1);
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; op = 4'd0;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
